// File: rtl/seg_crono_pkg.sv
// Shared types and constants for the seg_cronometro stopwatch.
//   crono_state_e : stopwatch state (STOP / RUN / HOLD)
//   bcd_time_t    : packed MM:SS value in BCD, one field per display digit
//   BCD_U_MAX     : highest units digit (9)
//   BCD_T_MAX     : highest tens digit for seconds/minutes (5)
//   DEF_*         : default parameter values for the top level
package seg_crono_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } crono_state_e;

    typedef struct packed {
        logic [2:0] min_d;
        logic [3:0] min_u;
        logic [2:0] sec_d;
        logic [3:0] sec_u;
    } bcd_time_t;

    localparam logic [3:0] BCD_U_MAX       = 4'd9;
    localparam logic [2:0] BCD_T_MAX       = 3'd5;
    localparam int         DEF_SYNC_STAGES = 2;
    localparam int         DEF_MIN_MAX     = 59;

endpackage

// File: rtl/seg_sync_edge.sv
// Synchroniser plus rising-edge detector for a slow asynchronous input.
//   clk   in  : sampling clock
//   rst   in  : asynchronous active-high reset
//   din   in  : asynchronous level to be synchronised
//   rise  out : combinational rising-edge indication, valid one cycle before tick
//   tick  out : registered one-cycle pulse per detected rising edge
// STAGES is the synchroniser depth and must be at least 2.
// A rising edge of din first sampled on edge 0 raises tick during the cycle
// after edge STAGES.
module seg_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic tick
);

    logic [STAGES-1:0] sync;
    logic [STAGES:0]   arm_sr;
    logic              prev;
    logic              sync_out;
    logic              armed;

    assign sync_out = sync[STAGES-1];

    // armed only rises once every synchroniser flop and prev hold real samples
    // taken after reset release. A level that was already high at release
    // therefore never looks like an edge coming out of the reset-zero chain.
    assign armed = arm_sr[STAGES];
    assign rise  = armed & sync_out & ~prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            arm_sr <= '0;
            prev   <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync   <= {sync[STAGES-2:0], din};
            arm_sr <= {arm_sr[STAGES-1:0], 1'b1};
            prev   <= sync_out;
            tick   <= rise;
        end
    end

endmodule

// File: rtl/seg_cronometro.sv
// MM:SS start/stop/clear stopwatch driven by the board's 1 s square wave.
//   mclk        in  : 50 MHz system clock
//   reset       in  : asynchronous active-high reset
//   seg_in      in  : asynchronous 1 s square wave; each rising edge is one second
//   start_stop  in  : one-cycle pulse, toggles run/stop
//   clear       in  : one-cycle pulse, zeroes the count and stops (highest priority)
//   lap         in  : one-cycle pulse, freezes/unfreezes the display (lap build only)
//   sec_u/sec_d : BCD seconds digits
//   min_u/min_d : BCD minutes digits
//   tick_o      out : one-cycle pulse per seg_in rising edge, regardless of state
//   running     out : registered "not STOP", lags the state by one cycle
//   wrap_o      out : one-cycle pulse when MIN_MAX:59 rolls over to 00:00
// Build option: define SEG_CRONO_LAP_EN to enable the HOLD (lap) state.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_STOP | count frozen, ticks ignored by the counter
// ST_RUN  | counter advances on every tick, outputs show live count
// ST_HOLD | counter advances, outputs show the frozen lap copy
module seg_cronometro
    import seg_crono_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_MAX     = DEF_MIN_MAX
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       seg_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_u,
    output logic [2:0] sec_d,
    output logic [3:0] min_u,
    output logic [2:0] min_d,
    output logic       tick_o,
    output logic       running,
    output logic       wrap_o
);

    localparam logic [2:0] MIN_D_MAX = 3'(MIN_MAX / 10);
    localparam logic [3:0] MIN_U_MAX = 4'(MIN_MAX % 10);

    crono_state_e state;
    bcd_time_t    live;
    bcd_time_t    nxt;
    bcd_time_t    shown;
    logic         rise;
    logic         adv;
    logic         at_max;

    seg_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk  (mclk),
        .rst  (reset),
        .din  (seg_in),
        .rise (rise),
        .tick (tick_o)
    );

    // The counter uses the pre-register edge so it moves on the same clock
    // edge that raises tick_o.
    assign adv = rise & (state != ST_STOP);

    assign at_max = (live.min_d == MIN_D_MAX) && (live.min_u == MIN_U_MAX) &&
                    (live.sec_d == BCD_T_MAX) && (live.sec_u == BCD_U_MAX);

    always_comb begin
        nxt = live;
        if (at_max) begin
            nxt = '0;
        end else if (live.sec_u != BCD_U_MAX) begin
            nxt.sec_u = live.sec_u + 4'd1;
        end else begin
            nxt.sec_u = '0;
            if (live.sec_d != BCD_T_MAX) begin
                nxt.sec_d = live.sec_d + 3'd1;
            end else begin
                nxt.sec_d = '0;
                if (live.min_u != BCD_U_MAX) begin
                    nxt.min_u = live.min_u + 4'd1;
                end else begin
                    nxt.min_u = '0;
                    nxt.min_d = live.min_d + 3'd1;
                end
            end
        end
    end

    // A coincident tick is applied with the old state before the transition
    // takes effect, so stopping in a tick cycle still counts that second.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state   <= ST_STOP;
            live    <= '0;
            running <= 1'b0;
            wrap_o  <= 1'b0;
        end else begin
            running <= (state != ST_STOP);
            wrap_o  <= 1'b0;
            if (clear) begin
                live  <= '0;
                state <= ST_STOP;
            end else begin
                if (adv) begin
                    live   <= nxt;
                    wrap_o <= at_max;
                end
                case (state)
                    ST_STOP: begin
                        if (start_stop) state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (start_stop) state <= ST_STOP;
`ifdef SEG_CRONO_LAP_EN
                        else if (lap) state <= ST_HOLD;
`endif
                    end
`ifdef SEG_CRONO_LAP_EN
                    ST_HOLD: begin
                        if (start_stop) state <= ST_STOP;
                        else if (lap)   state <= ST_RUN;
                    end
`endif
                    default: state <= ST_STOP;
                endcase
            end
        end
    end

`ifdef SEG_CRONO_LAP_EN
    bcd_time_t disp;
    logic      hold_enter;

    // start_stop wins over lap in RUN, so only a lone lap freezes the display.
    assign hold_enter = (state == ST_RUN) & lap & ~start_stop;

    // The frozen copy includes a tick landing on the same edge, matching what
    // the live count reads the cycle after the lap press.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            disp <= '0;
        end else if (clear) begin
            disp <= '0;
        end else if (hold_enter) begin
            disp <= adv ? nxt : live;
        end
    end

    assign shown = (state == ST_HOLD) ? disp : live;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign shown      = live;
`endif

    assign sec_u = shown.sec_u;
    assign sec_d = shown.sec_d;
    assign min_u = shown.min_u;
    assign min_d = shown.min_d;

endmodule

// File: tb/tb_seg_cronometro.sv
module tb_seg_cronometro;

    localparam int S      = 2;
    localparam int MINMAX = 59;
    localparam int TOTAL  = (MINMAX + 1) * 60;
    localparam int HMAX   = 65536;
`ifdef SEG_CRONO_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       mclk = 1'b0;
    logic       reset;
    logic       seg_in;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] sec_u;
    logic [2:0] sec_d;
    logic [3:0] min_u;
    logic [2:0] min_d;
    logic       tick_o;
    logic       running;
    logic       wrap_o;

    seg_cronometro #(
        .SYNC_STAGES (S),
        .MIN_MAX     (MINMAX)
    ) dut (
        .mclk       (mclk),
        .reset      (reset),
        .seg_in     (seg_in),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .sec_u      (sec_u),
        .sec_d      (sec_d),
        .min_u      (min_u),
        .min_d      (min_d),
        .tick_o     (tick_o),
        .running    (running),
        .wrap_o     (wrap_o)
    );

    always #10 mclk = ~mclk;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    // seg_in level seen at each clock edge since the last reset release
    bit hist [0:HMAX-1];
    int k;

    // square-wave generator: toggles every gen_half cycles, holds when 0
    bit seg_lvl;
    int gen_half;
    int gen_cnt;

    // behavioural model: total elapsed seconds, frozen lap copy, state 0/1/2
    int m_total, m_disp, m_st;
    bit m_tick, m_wrap, m_run;

    int tick_seen, wrap_seen, first_tick;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tick_at(input int e);
        if (e < S + 1) return 1'b0;
        return hist[e-S] & ~hist[e-S-1];
    endfunction

    function automatic bit tick_next();
        return tick_at(k);
    endfunction

    task automatic model_reset();
        m_total = 0; m_disp = 0; m_st = 0;
        m_tick = 0; m_wrap = 0; m_run = 0;
        k = 0;
    endtask

    task automatic model_edge(input bit ss, input bit clr, input bit lp);
        bit tk;
        tk     = tick_at(k);
        m_tick = tk;
        m_run  = (m_st != 0);
        m_wrap = 1'b0;
        if (clr) begin
            m_total = 0;
            m_disp  = 0;
            m_st    = 0;
        end else begin
            if (m_st != 0 && tk) begin
                if (m_total == TOTAL - 1) begin
                    m_total = 0;
                    m_wrap  = 1'b1;
                end else begin
                    m_total++;
                end
            end
            case (m_st)
                0: if (ss) m_st = 1;
                1: begin
                    if (ss) m_st = 0;
                    else if (LAP && lp) begin
                        m_st   = 2;
                        m_disp = m_total;
                    end
                end
                default: begin
                    if (ss) m_st = 0;
                    else if (lp) m_st = 1;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        int sh, sc, mn;
        sh = (LAP && m_st == 2) ? m_disp : m_total;
        sc = sh % 60;
        mn = sh / 60;
        chk("sec_u",   sec_u,   sc % 10);
        chk("sec_d",   sec_d,   sc / 10);
        chk("min_u",   min_u,   mn % 10);
        chk("min_d",   min_d,   mn / 10);
        chk("tick_o",  tick_o,  m_tick);
        chk("wrap_o",  wrap_o,  m_wrap);
        chk("running", running, m_run);
    endtask

    // one clock: drive at the falling edge, model at the rising edge,
    // compare at the next falling edge
    task automatic step(input bit ss, input bit clr, input bit lp);
        start_stop = ss;
        clear      = clr;
        lap        = lp;
        seg_in     = seg_lvl;
        @(posedge mclk);
        hist[k] = seg_lvl;
        model_edge(ss, clr, lp);
        k++;
        if (gen_half > 0) begin
            gen_cnt++;
            if (gen_cnt >= gen_half) begin
                gen_cnt = 0;
                seg_lvl = ~seg_lvl;
            end
        end
        @(negedge mclk);
        compare_all();
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        if (tick_o) tick_seen++;
        if (wrap_o) wrap_seen++;
        if (tick_o && first_tick < 0) first_tick = k - 1;
        ncyc++;
        if (ncyc > 80000 || k >= HMAX - 1) begin
            errors++;
            $display("FAIL cycle_budget: got %0d cycles expected at most 80000", ncyc);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic do_reset(input bit lvl);
        reset      = 1'b1;
        seg_lvl    = lvl;
        seg_in     = lvl;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        gen_half   = 0;
        gen_cnt    = 0;
        model_reset();
        repeat (3) @(negedge mclk);
        compare_all();
        reset = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            if (tick_next()) c++;
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_tick();
        while (!tick_next()) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_quiet();
        while (tick_next()) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; seg_in = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        tick_seen = 0; wrap_seen = 0; first_tick = -1;

        // seg_in already high at release, then a 20-cycle square wave
        do_reset(1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        seg_lvl = 1'b0; gen_cnt = 0; gen_half = 10;
        repeat (60) step(1'b0, 1'b0, 1'b0);
        chk("first_tick_edge", first_tick, 22);
        chk("initial_tick_count", tick_seen, 3);

        // start, then 75 seconds
        gen_half = 2;
        wait_quiet();
        step(1'b1, 1'b0, 1'b0);
        run_ticks(75);
        chk("t75_min_d", min_d, 0);
        chk("t75_min_u", min_u, 1);
        chk("t75_sec_d", sec_d, 1);
        chk("t75_sec_u", sec_u, 5);
        chk("t75_running", running, 1);

        // up to 59:59, then roll over
        run_ticks(3524);
        chk("max_min_d", min_d, 5);
        chk("max_min_u", min_u, 9);
        chk("max_sec_d", sec_d, 5);
        chk("max_sec_u", sec_u, 9);
        wrap_seen = 0;
        run_ticks(1);
        chk("wrap_sec_u", sec_u, 0);
        chk("wrap_min_d", min_d, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("wrap_pulse_count", wrap_seen, 1);

        // clear coincident with a tick and start_stop at 00:07
        run_ticks(7);
        chk("pre_clear_sec_u", sec_u, 7);
        wait_tick();
        step(1'b1, 1'b1, 1'b0);
        chk("clear_sec_u", sec_u, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("clear_running", running, 0);

        // ticks in STOP, then start on a tick cycle
        tick_seen = 0;
        run_ticks(10);
        chk("stop_tick_count", tick_seen, 10);
        chk("stop_sec_u", sec_u, 0);
        wait_tick();
        step(1'b1, 1'b0, 1'b0);
        chk("start_on_tick_sec_u", sec_u, 0);
        run_ticks(3);
        chk("after_start_sec_u", sec_u, 3);

        // lap behaviour from 00:30
        wait_quiet();
        step(1'b0, 1'b1, 1'b0);
        wait_quiet();
        step(1'b1, 1'b0, 1'b0);
        run_ticks(30);
        chk("lap_base_sec_d", sec_d, 3);
        chk("lap_base_sec_u", sec_u, 0);
        wait_quiet();
        step(1'b0, 1'b0, 1'b1);
        run_ticks(5);
`ifdef SEG_CRONO_LAP_EN
        chk("hold_sec_d", sec_d, 3);
        chk("hold_sec_u", sec_u, 0);
        wait_quiet();
        step(1'b0, 1'b0, 1'b1);
        chk("release_sec_d", sec_d, 3);
        chk("release_sec_u", sec_u, 5);
`else
        chk("nolap_sec_d", sec_d, 3);
        chk("nolap_sec_u", sec_u, 5);
`endif

        // randomised traffic with one asynchronous reset part way through
        for (int i = 0; i < 4000; i++) begin
            int r;
            if (i % 500 == 0) gen_half = $urandom_range(1, 4);
            if (i == 2000) begin
                do_reset(1'($urandom_range(0, 1)));
                gen_half = $urandom_range(1, 4);
            end
            r = $urandom_range(0, 99);
            step(r < 4, r == 50, r >= 90 && r < 96);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
